// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and constants for the 5-stage pipeline hazard controller:
// FSM state encoding, forwarding select codes and a register-match helper.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } state_t;

  typedef logic [1:0] fwd_sel_t;

  localparam fwd_sel_t FWD_RF  = 2'b00;
  localparam fwd_sel_t FWD_EXM = 2'b10;
  localparam fwd_sel_t FWD_WB  = 2'b01;

  localparam int REG_W  = 5;
  localparam int WAIT_W = 10;

  // True when a writing stage targets a real register (not x0) that matches rs.
  function automatic logic reg_match(input logic             wr,
                                     input logic [REG_W-1:0] rd,
                                     input logic [REG_W-1:0] rs);
    return wr && (rd != '0) && (rd == rs);
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Pipeline-side bundle: register fields and memory handshake in, stage
// enables / flushes / forwarding selects out.
interface pipeline_hazard_ctrl_if;

  logic [4:0] ifid_rs1;
  logic [4:0] ifid_rs2;
  logic [4:0] idex_rs1;
  logic [4:0] idex_rs2;
  logic [4:0] idex_rd;
  logic       idex_memread;
  logic [4:0] exm_rd;
  logic       exm_regwrite;
  logic [4:0] mwb_rd;
  logic       mwb_regwrite;
  logic       branch_taken;
  logic       dmem_req;
  logic       dmem_ack;

  logic       pc_write;
  logic       ifid_write;
  logic       idex_write;
  logic       exm_write;
  logic       ifid_flush;
  logic       idex_flush;
  logic       exm_flush;
  logic       idex_bubble;
  logic       mwb_bubble;
  logic [1:0] fwd_a;
  logic [1:0] fwd_b;

  modport master (
    output ifid_rs1, ifid_rs2, idex_rs1, idex_rs2, idex_rd, idex_memread,
           exm_rd, exm_regwrite, mwb_rd, mwb_regwrite,
           branch_taken, dmem_req, dmem_ack,
    input  pc_write, ifid_write, idex_write, exm_write,
           ifid_flush, idex_flush, exm_flush, idex_bubble, mwb_bubble,
           fwd_a, fwd_b
  );

  modport slave (
    input  ifid_rs1, ifid_rs2, idex_rs1, idex_rs2, idex_rd, idex_memread,
           exm_rd, exm_regwrite, mwb_rd, mwb_regwrite,
           branch_taken, dmem_req, dmem_ack,
    output pc_write, ifid_write, idex_write, exm_write,
           ifid_flush, idex_flush, exm_flush, idex_bubble, mwb_bubble,
           fwd_a, fwd_b
  );

endinterface

// File: rtl/pipeline_hazard_ctrl_fwd.sv
// EX-stage operand forwarding select for one source register; the younger
// EX_MEM result takes precedence over the WB write data.
module forwarding_unit
  import pipe_ctrl_pkg::*;
(
  input  logic [REG_W-1:0] rs,
  input  logic [REG_W-1:0] exm_rd,
  input  logic             exm_regwrite,
  input  logic [REG_W-1:0] mwb_rd,
  input  logic             mwb_regwrite,
  output fwd_sel_t         fwd_sel
);

  always_comb begin
    fwd_sel = FWD_RF;
    if (reg_match(exm_regwrite, exm_rd, rs)) begin
      fwd_sel = FWD_EXM;
    end else if (reg_match(mwb_regwrite, mwb_rd, rs)) begin
      fwd_sel = FWD_WB;
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and sequencing controller: memory wait-state FSM with timeout,
// branch flush, load-use stall, operand forwarding and performance counters.
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 reset,
  pipeline_hazard_ctrl_if.slave hz,
  output logic [CNT_W-1:0]     stall_cycles,
  output logic [CNT_W-1:0]     flush_events,
  output logic                 mem_err
);

  localparam logic [WAIT_W-1:0] TIMEOUT_CNT = WAIT_W'(TIMEOUT);

  state_t            state_reg, state_next;
  logic [WAIT_W-1:0] wait_cnt_reg, wait_cnt_next;
  logic [CNT_W-1:0]  stall_cycles_reg, stall_cycles_next;
  logic [CNT_W-1:0]  flush_events_reg, flush_events_next;
  logic              mem_err_reg, mem_err_next;

  logic freeze;
  logic load_use;
  logic pc_write, ifid_write, idex_write, exm_write;
  logic ifid_flush, idex_flush, exm_flush;
  logic idex_bubble, mwb_bubble;

  // ------------------------------------------------------------------
  // Forwarding: one unit per ALU operand
  // ------------------------------------------------------------------
  logic [REG_W-1:0] fwd_rs  [2];
  fwd_sel_t         fwd_sel [2];

  assign fwd_rs[0] = hz.idex_rs1;
  assign fwd_rs[1] = hz.idex_rs2;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
      forwarding_unit u_fwd (
        .rs           (fwd_rs[gi]),
        .exm_rd       (hz.exm_rd),
        .exm_regwrite (hz.exm_regwrite),
        .mwb_rd       (hz.mwb_rd),
        .mwb_regwrite (hz.mwb_regwrite),
        .fwd_sel      (fwd_sel[gi])
      );
    end
  endgenerate

  assign hz.fwd_a = fwd_sel[0];
  assign hz.fwd_b = fwd_sel[1];

  // ------------------------------------------------------------------
  // Hazard detection
  // ------------------------------------------------------------------
  assign load_use = reg_match(hz.idex_memread, hz.idex_rd, hz.ifid_rs1) ||
                    reg_match(hz.idex_memread, hz.idex_rd, hz.ifid_rs2);

  // The ack cycle of a wait already releases the pipeline.
  always_comb begin
    freeze = 1'b0;
    case (state_reg)
      RUN:      freeze = hz.dmem_req && !hz.dmem_ack;
      MEM_WAIT: freeze = !hz.dmem_ack;
      ERROR:    freeze = 1'b1;
      default:  freeze = 1'b0;
    endcase
  end

  // ------------------------------------------------------------------
  // FSM: state register
  // ------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= RUN;
      wait_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;
    end
  end

  // ------------------------------------------------------------------
  // FSM: next state and wait counter
  // ------------------------------------------------------------------
  always_comb begin
    state_next    = state_reg;
    wait_cnt_next = wait_cnt_reg;
    case (state_reg)
      RUN: begin
        if (hz.dmem_req && !hz.dmem_ack) begin
          state_next    = MEM_WAIT;
          wait_cnt_next = WAIT_W'(1);
        end
      end
      MEM_WAIT: begin
        if (hz.dmem_ack) begin
          state_next    = RUN;
          wait_cnt_next = '0;
        end else if (wait_cnt_reg == TIMEOUT_CNT) begin
          state_next    = ERROR;
        end else begin
          wait_cnt_next = wait_cnt_reg + WAIT_W'(1);
        end
      end
      ERROR: begin
        state_next = ERROR;
      end
      default: begin
        state_next    = RUN;
        wait_cnt_next = '0;
      end
    endcase
  end

  // ------------------------------------------------------------------
  // FSM: outputs (freeze > branch flush > load-use stall > normal)
  // ------------------------------------------------------------------
  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    idex_write  = 1'b1;
    exm_write   = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exm_flush   = 1'b0;
    idex_bubble = 1'b0;
    mwb_bubble  = 1'b0;
    if (freeze) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      idex_write = 1'b0;
      exm_write  = 1'b0;
      mwb_bubble = 1'b1;
    end else if (hz.branch_taken) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
      exm_flush  = 1'b1;
    end else if (load_use) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
    end
  end

  assign hz.pc_write    = pc_write;
  assign hz.ifid_write  = ifid_write;
  assign hz.idex_write  = idex_write;
  assign hz.exm_write   = exm_write;
  assign hz.ifid_flush  = ifid_flush;
  assign hz.idex_flush  = idex_flush;
  assign hz.exm_flush   = exm_flush;
  assign hz.idex_bubble = idex_bubble;
  assign hz.mwb_bubble  = mwb_bubble;

  // ------------------------------------------------------------------
  // Performance counters (saturating) and sticky timeout error
  // ------------------------------------------------------------------
  always_comb begin
    stall_cycles_next = stall_cycles_reg;
    flush_events_next = flush_events_reg;
    if (!pc_write && (stall_cycles_reg != '1)) begin
      stall_cycles_next = stall_cycles_reg + CNT_W'(1);
    end
    if (ifid_flush && (flush_events_reg != '1)) begin
      flush_events_next = flush_events_reg + CNT_W'(1);
    end
    mem_err_next = mem_err_reg || (state_next == ERROR);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cycles_reg <= '0;
      flush_events_reg <= '0;
      mem_err_reg      <= 1'b0;
    end else begin
      stall_cycles_reg <= stall_cycles_next;
      flush_events_reg <= flush_events_next;
      mem_err_reg      <= mem_err_next;
    end
  end

  assign stall_cycles = stall_cycles_reg;
  assign flush_events = flush_events_reg;
  assign mem_err      = mem_err_reg;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl (TIMEOUT=8): load-use, forwarding,
// branch flush, memory wait, timeout/error and asynchronous reset.
module tb_pipeline_hazard_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] stall_cycles;
  logic [31:0] flush_events;
  logic        mem_err;

  int chk_cnt = 0;
  int err_cnt = 0;

  // {pc, ifid, idex, exm writes, ifid/idex/exm flush, idex_bubble, mwb_bubble}
  localparam logic [8:0] C_NORMAL = 9'b1111_000_0_0;
  localparam logic [8:0] C_STALL  = 9'b0011_000_1_0;
  localparam logic [8:0] C_FLUSH  = 9'b1111_111_0_0;
  localparam logic [8:0] C_FREEZE = 9'b0000_000_0_1;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl_if hz ();

  pipeline_hazard_ctrl #(
    .CNT_W   (32),
    .TIMEOUT (8)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .hz           (hz),
    .stall_cycles (stall_cycles),
    .flush_events (flush_events),
    .mem_err      (mem_err)
  );

  logic [8:0] ctrl;
  assign ctrl = {hz.pc_write, hz.ifid_write, hz.idex_write, hz.exm_write,
                 hz.ifid_flush, hz.idex_flush, hz.exm_flush,
                 hz.idex_bubble, hz.mwb_bubble};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic clear_inputs();
    hz.ifid_rs1 = '0;  hz.ifid_rs2 = '0;
    hz.idex_rs1 = '0;  hz.idex_rs2 = '0;  hz.idex_rd = '0;
    hz.idex_memread = 1'b0;
    hz.exm_rd = '0;    hz.exm_regwrite = 1'b0;
    hz.mwb_rd = '0;    hz.mwb_regwrite = 1'b0;
    hz.branch_taken = 1'b0;
    hz.dmem_req = 1'b0;
    hz.dmem_ack = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    clear_inputs();

    // Reset state
    @(negedge clk);
    chk("reset_ctrl", 32'(ctrl), 32'(C_NORMAL));
    chk("reset_fwd", {28'd0, hz.fwd_a, hz.fwd_b}, 32'h0);
    chk("reset_stall_cnt", stall_cycles, 32'd0);
    chk("reset_flush_cnt", flush_events, 32'd0);
    chk("reset_mem_err", 32'(mem_err), 32'd0);
    @(posedge clk);
    #1 reset = 1'b1;

    // Load-use: ld x5 in EX, add x6,x5,x7 in ID
    hz.idex_memread = 1'b1; hz.idex_rd = 5'd5;
    hz.ifid_rs1 = 5'd5;     hz.ifid_rs2 = 5'd7;
    @(negedge clk);
    chk("loaduse_stall", 32'(ctrl), 32'(C_STALL));
    next_cycle();
    clear_inputs();
    hz.ifid_rs1 = 5'd5; hz.ifid_rs2 = 5'd7;
    hz.exm_rd = 5'd5;   hz.exm_regwrite = 1'b1;
    @(negedge clk);
    chk("loaduse_one_bubble", 32'(ctrl), 32'(C_NORMAL));
    chk("loaduse_stall_cnt", stall_cycles, 32'd1);
    next_cycle();
    clear_inputs();
    hz.idex_rs1 = 5'd5; hz.idex_rs2 = 5'd7;
    hz.mwb_rd = 5'd5;   hz.mwb_regwrite = 1'b1;
    @(negedge clk);
    chk("loaduse_fwd_a_wb", 32'(hz.fwd_a), 32'(2'b01));
    chk("loaduse_fwd_b_rf", 32'(hz.fwd_b), 32'(2'b00));
    next_cycle();

    // Forwarding: x3 in MEM and WB, EX reads x3 twice
    clear_inputs();
    hz.idex_rs1 = 5'd3; hz.idex_rs2 = 5'd3;
    hz.exm_rd = 5'd3;   hz.exm_regwrite = 1'b1;
    hz.mwb_rd = 5'd3;   hz.mwb_regwrite = 1'b1;
    @(negedge clk);
    chk("fwd_a_exm", 32'(hz.fwd_a), 32'(2'b10));
    chk("fwd_b_exm_over_wb", 32'(hz.fwd_b), 32'(2'b10));
    next_cycle();
    clear_inputs();
    hz.idex_rs1 = 5'd0; hz.idex_rs2 = 5'd9;
    hz.exm_rd = 5'd0;   hz.exm_regwrite = 1'b1;
    hz.mwb_rd = 5'd9;   hz.mwb_regwrite = 1'b1;
    @(negedge clk);
    chk("fwd_a_x0", 32'(hz.fwd_a), 32'(2'b00));
    chk("fwd_b_wb", 32'(hz.fwd_b), 32'(2'b01));
    next_cycle();
    clear_inputs();
    hz.idex_rs1 = 5'd4; hz.exm_rd = 5'd4; hz.exm_regwrite = 1'b0;
    @(negedge clk);
    chk("fwd_a_no_regwrite", 32'(hz.fwd_a), 32'(2'b00));
    next_cycle();

    // Branch taken together with a load-use condition
    clear_inputs();
    hz.branch_taken = 1'b1;
    hz.idex_memread = 1'b1; hz.idex_rd = 5'd4; hz.ifid_rs2 = 5'd4;
    @(negedge clk);
    chk("branch_flush", 32'(ctrl), 32'(C_FLUSH));
    next_cycle();
    clear_inputs();
    chk("branch_flush_cnt", flush_events, 32'd1);
    chk("branch_no_stall", stall_cycles, 32'd1);

    // Memory wait: ack after 4 cycles, branch during wait ignored
    hz.dmem_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      hz.branch_taken = (i == 2);
      @(negedge clk);
      chk($sformatf("memwait_freeze_%0d", i), 32'(ctrl), 32'(C_FREEZE));
      next_cycle();
    end
    hz.branch_taken = 1'b0;
    hz.dmem_ack = 1'b1;
    @(negedge clk);
    chk("memwait_release", 32'(ctrl), 32'(C_NORMAL));
    next_cycle();
    clear_inputs();
    chk("memwait_stall_cnt", stall_cycles, 32'd5);
    chk("memwait_flush_cnt", flush_events, 32'd1);

    // Timeout: ack never comes
    hz.dmem_req = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk($sformatf("timeout_freeze_%0d", i), 32'(ctrl), 32'(C_FREEZE));
      next_cycle();
    end
    chk("timeout_not_yet", 32'(mem_err), 32'd0);
    next_cycle();
    chk("timeout_mem_err", 32'(mem_err), 32'd1);
    chk("timeout_stall_cnt", stall_cycles, 32'd14);
    hz.dmem_req = 1'b0; hz.dmem_ack = 1'b1;
    @(negedge clk);
    chk("error_frozen", 32'(ctrl), 32'(C_FREEZE));
    chk("error_sticky", 32'(mem_err), 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("error_reset_mem_err", 32'(mem_err), 32'd0);
    chk("error_reset_stall_cnt", stall_cycles, 32'd0);
    chk("error_reset_ctrl", 32'(ctrl), 32'(C_NORMAL));
    next_cycle();
    reset = 1'b1;
    clear_inputs();

    // Reset in the middle of a memory wait
    hz.dmem_req = 1'b1;
    next_cycle();
    next_cycle();
    @(negedge clk);
    chk("midwait_freeze", 32'(ctrl), 32'(C_FREEZE));
    clear_inputs();
    #2 reset = 1'b0;
    #1;
    chk("midwait_reset_ctrl", 32'(ctrl), 32'(C_NORMAL));
    chk("midwait_reset_stall_cnt", stall_cycles, 32'd0);
    chk("midwait_reset_flush_cnt", flush_events, 32'd0);
    next_cycle();
    reset = 1'b1;
    @(negedge clk);
    chk("midwait_run_ctrl", 32'(ctrl), 32'(C_NORMAL));
    next_cycle();
    chk("midwait_run_stall_cnt", stall_cycles, 32'd0);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
